// File: rtl/icache_pkg.sv
// Shared widths, constants and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;
    localparam int          ADDR_W  = 32;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] NULL32  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REFILL  = 2'd1,
        S_RESPOND = 2'd2
    } state_e;
endpackage

// File: rtl/icache_line_ram.sv
// Line data array: one full-line write port, one asynchronous full-line read port.
module icache_line_ram
    import icache_pkg::*;
#(
    parameter int LINE_NUM   = 64,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(LINE_NUM)
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [IDX_W-1:0]                      waddr,
    input  logic [LINE_WORDS-1:0][INSTR_W-1:0]    wdata,
    input  logic [IDX_W-1:0]                      raddr,
    output logic [LINE_WORDS-1:0][INSTR_W-1:0]    rdata
);
    logic [LINE_WORDS-1:0][INSTR_W-1:0] mem [LINE_NUM];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with whole-line refill and flush-tolerant misses.
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM   = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                icache_enable,
    input  logic [ADDR_W-1:0]   pc_to_fetch,
    input  logic                jump_wrong,
    output logic [INSTR_W-1:0]  instr_fetched,
    output logic                icache_success,
    output logic                mem_enable,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [INSTR_W-1:0]  mem_data,
    input  logic                mem_success
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINE_NUM);
    localparam int IDX_LO = OFF_W + 2;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = ADDR_W - TAG_LO;

    state_e                              state;
    logic [ADDR_W-1:0]                   pc_q;
    logic [OFF_W-1:0]                    cnt, cnt_nxt;
    logic                                kill;
    logic                                succ_q;
    logic [LINE_NUM-1:0]                 valid;
    logic [TAG_W-1:0]                    tag_arr [LINE_NUM];
    logic [LINE_WORDS-1:0][INSTR_W-1:0]  fill_buf, line_wdata, line_rdata;

    logic [IDX_W-1:0] req_idx, q_idx, rd_idx;
    logic [TAG_W-1:0] req_tag, q_tag;
    logic [OFF_W-1:0] req_off, q_off;
    logic             hit, accept, last, fill_done, unused_bits;

    assign req_idx = pc_to_fetch[TAG_LO-1:IDX_LO];
    assign req_tag = pc_to_fetch[ADDR_W-1:TAG_LO];
    assign req_off = pc_to_fetch[IDX_LO-1:2];
    assign q_idx   = pc_q[TAG_LO-1:IDX_LO];
    assign q_tag   = pc_q[ADDR_W-1:TAG_LO];
    assign q_off   = pc_q[IDX_LO-1:2];
    assign unused_bits = ^{pc_to_fetch[1:0], pc_q[1:0]};

    assign hit     = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    // Holding off while a pulse is out keeps a still-held request from firing twice.
    assign accept  = (state == S_IDLE) && icache_enable && !jump_wrong && !succ_q;
    assign last    = (cnt == OFF_W'(LINE_WORDS - 1));
    assign cnt_nxt = cnt + OFF_W'(1);
    assign fill_done = (state == S_REFILL) && mem_success && last;
    assign rd_idx  = (state == S_IDLE) ? req_idx : q_idx;

    // The final word bypasses fill_buf so the line commits on the same edge it arrives.
    always_comb begin
        line_wdata      = fill_buf;
        line_wdata[cnt] = mem_data;
    end

    icache_line_ram #(
        .LINE_NUM   (LINE_NUM),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_ram (
        .clk   (clk),
        .we    (fill_done && rdy && !rst),
        .waddr (q_idx),
        .wdata (line_wdata),
        .raddr (rd_idx),
        .rdata (line_rdata)
    );

    assign icache_success = succ_q && rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            valid         <= '0;
            cnt           <= '0;
            kill          <= 1'b0;
            succ_q        <= 1'b0;
            instr_fetched <= NULL32;
            mem_enable    <= 1'b0;
            mem_addr      <= NULL32;
            pc_q          <= NULL32;
        end else if (rdy) begin
            succ_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            succ_q        <= 1'b1;
                            instr_fetched <= line_rdata[req_off];
                        end else begin
                            pc_q       <= pc_to_fetch;
                            cnt        <= '0;
                            mem_enable <= 1'b1;
                            mem_addr   <= {pc_to_fetch[ADDR_W-1:IDX_LO], {OFF_W{1'b0}}, 2'b00};
                            state      <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (jump_wrong) kill <= 1'b1;
                    if (mem_success) begin
                        fill_buf[cnt] <= mem_data;
                        if (last) begin
                            valid[q_idx]   <= 1'b1;
                            tag_arr[q_idx] <= q_tag;
                            mem_enable     <= 1'b0;
                            cnt            <= '0;
                            kill           <= 1'b0;
                            state          <= (kill || jump_wrong) ? S_IDLE : S_RESPOND;
                        end else begin
                            cnt      <= cnt_nxt;
                            mem_addr <= {pc_q[ADDR_W-1:IDX_LO], cnt_nxt, 2'b00};
                        end
                    end
                end
                S_RESPOND: begin
                    if (!jump_wrong) begin
                        succ_q        <= 1'b1;
                        instr_fetched <= line_rdata[q_off];
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINE_NUM, default 64, number of direct-mapped lines.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global ready; while low, all state and outputs hold.
REQ-006 icache_enable  input  1  fetch request valid from IF.
REQ-007 pc_to_fetch  input  32  byte address of the requested instruction; bits [1:0] are ignored.
REQ-008 jump_wrong  input  1  ROB mispredict flush; kills any pending fetch.
REQ-009 instr_fetched  output  32  returned instruction, valid only with icache_success.
REQ-010 icache_success  output  1  one-cycle pulse: instr_fetched is valid for the current request.
REQ-011 mem_enable  output  1  word read request to the memory controller.
REQ-012 mem_addr  output  32  word-aligned read address.
REQ-013 mem_data  input  32  read data from the memory controller.
REQ-014 mem_success  input  1  one-cycle pulse: mem_data is valid; the current word read is done.

Function
REQ-015 Address split: offset [3:2] selects the word, index [9:4] selects the line, tag [31:10]; widths follow the parameters.
REQ-016 Per-line state: valid bit, 22-bit tag, LINE_WORDS data words.
REQ-017 States: IDLE, REFILL, RESPOND.
REQ-018 IDLE, enable=1, jump_wrong=0, hit: on the next edge, success=1 and instr_fetched=word; state stays IDLE (1-cycle hit latency).
REQ-019 IDLE, enable=1, jump_wrong=0, miss: latch the pc, clear the word counter, go to REFILL.
REQ-020 REFILL: mem_enable=1; mem_addr={tag,index,counter,2'b00}, held stable until mem_success.
REQ-021 On mem_success: write mem_data into the fill buffer at the counter position, then increment the counter.
REQ-022 The word order within a line is 0 to LINE_WORDS-1.
REQ-023 After the last word: commit the fill buffer to the line, set valid, write the tag, deassert mem_enable.
REQ-024 After the commit, enter RESPOND, unless the kill flag is set, in which case enter IDLE.
REQ-025 RESPOND: success=1 for exactly one cycle with the latched-offset word, then go to IDLE.
REQ-026 icache_success is never high for two consecutive cycles; it is 0 in every cycle not named above.
REQ-027 The requester holds enable and pc until success; the cache samples pc only in IDLE.
REQ-028 jump_wrong in IDLE: no request is accepted that cycle (jump_wrong wins over enable) and no success is produced.
REQ-029 jump_wrong in REFILL: set the kill flag; the refill runs to completion and commits, so the memory-controller handshake is never abandoned mid-word.
REQ-030 jump_wrong in RESPOND: suppress the success pulse; go to IDLE.
REQ-031 mem_success outside REFILL is ignored.
REQ-032 No write or invalidate port exists; instruction memory is read-only.
REQ-033 rdy=0: freeze state, the counter, mem_enable and mem_addr; force icache_success=0 that cycle.
REQ-034 A missed pulse caused by rdy=0 is re-issued once rdy returns.

Reset
REQ-035 rst=1: state=IDLE, all valid bits=0, counter=0, kill flag=0.
REQ-036 rst=1: icache_success=0, instr_fetched=0, mem_enable=0, mem_addr=0.
REQ-037 Reset mid-REFILL abandons the fill; the partial line is never marked valid.
REQ-038 Reset overrides rdy and jump_wrong.

Structure
REQ-039 define.v holds `ADDR, `INSTRLEN, `TRUE/`FALSE, `NULL32 and the new ICACHE index, tag and offset range macros.
REQ-040 Sub-module icache_line_ram: LINE_NUM x LINE_WORDS x 32 data array with one write port and one asynchronous read port.
REQ-041 Tag and valid arrays stay in icache.

Verification
REQ-042 After reset, pc=0x0000_0000 -> four mem reads 0x0,0x4,0x8,0xC; one success with word0; then pc=0x4 -> success next cycle, no mem_enable.
REQ-043 pc=0x0000_0408 after a line at 0x0000_0008 (same index, other tag) -> refill from 0x400..0x40C; success returns the 0x408 word; the old line is evicted.
REQ-044 jump_wrong pulse during the 2nd refill word -> the remaining 2 words still read; no success; a later request to the same pc hits in 1 cycle.
REQ-045 enable=1 and jump_wrong=1 in the same IDLE cycle -> no mem_enable, no success.
REQ-046 rdy=0 for 3 cycles mid-REFILL with mem_addr=0x8 -> mem_addr stays 0x8; a hit during rdy=0 delays success until rdy=1.
REQ-047 rst during REFILL -> mem_enable=0 next cycle; the same pc misses again afterwards.
